// File: rtl/stepdown_softstart_seq.sv
// Soft-start sequencer: start delay, then a prescaled reference ramp to full
// scale, with current-limit pause and abort-to-zero on disable/UVLO/fault.
module stepdown_softstart_seq #(
  parameter int CODE_W    = 6,
  parameter int PRESCALE  = 16,
  parameter int START_DLY = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              uvlo_ok,
  input  logic              fault,
  input  logic              ilim,
  output logic [CODE_W-1:0] ss_code,
  output logic              tstate,
  output logic              step_pulse,
  output logic              ss_ok,
  output logic              ss_done,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  localparam logic [CODE_W-1:0] FULL_M1 = {{(CODE_W-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0]     PS_TC   = PW'(PRESCALE - 1);
  localparam logic [DW-1:0]     DLY_TC  = DW'(START_DLY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RAMP,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [PW-1:0]     presc;
  logic [PW-1:0]     presc_d;
  logic [DW-1:0]     dly;
  logic [DW-1:0]     dly_d;
  logic [CODE_W-1:0] code_d;
  logic              step;
  logic              abort;
  logic              tstate_d;
  logic              pulse_d;
  logic              ok_d;
  logic              done_d;

  // Supply pins have no logic function here.
  wire unused_pins = &{1'b0, CELV, CELG, SUB};

  assign abort = !en || !uvlo_ok || fault;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      presc      <= '0;
      dly        <= '0;
      ss_code    <= '0;
      tstate     <= 1'b0;
      step_pulse <= 1'b0;
      ss_ok      <= 1'b0;
      ss_done    <= 1'b0;
    end else begin
      state      <= state_d;
      presc      <= presc_d;
      dly        <= dly_d;
      ss_code    <= code_d;
      tstate     <= tstate_d;
      step_pulse <= pulse_d;
      ss_ok      <= ok_d;
      ss_done    <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    presc_d = presc;
    dly_d   = dly;
    code_d  = ss_code;
    step    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      presc_d = '0;
      dly_d   = '0;
      code_d  = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_d = S_WAIT;
          dly_d   = '0;
        end
        S_WAIT: begin
          if (dly == DLY_TC) begin
            state_d = S_RAMP;
            presc_d = '0;
          end else begin
            dly_d = dly + 1'b1;
          end
        end
        S_RAMP: begin
          presc_d = (presc == PS_TC) ? '0 : presc + 1'b1;
          // ilim only matters at terminal count: it skips a whole slot
          if (presc == PS_TC && !ilim) begin
            step   = 1'b1;
            code_d = ss_code + 1'b1;
            if (ss_code == FULL_M1)
              state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
      endcase
    end
  end

  always_comb begin
    tstate_d = (state_d == S_RAMP);
    pulse_d  = step;
    ok_d     = !abort;
    done_d   = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_stepdown_softstart_seq.sv
// Bench for stepdown_softstart_seq: directed scenarios plus random traffic,
// all compared each cycle against an edge-count reference model.
module tb_stepdown_softstart_seq;

  localparam int CW   = 4;
  localparam int PS   = 4;
  localparam int SD   = 3;
  localparam int FULL = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b0;
  logic          uvlo_ok = 1'b0;
  logic          fault = 1'b0;
  logic          ilim = 1'b0;
  logic          CELV = 1'b1;
  logic          CELG = 1'b0;
  logic          SUB = 1'b0;
  logic [CW-1:0] ss_code;
  logic          tstate;
  logic          step_pulse;
  logic          ss_ok;
  logic          ss_done;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Model: edges since the enabling edge, and steps taken so far.
  bit m_act;
  int m_n;
  int m_code;
  bit m_pulse;
  bit m_ok;

  stepdown_softstart_seq #(
    .CODE_W(CW),
    .PRESCALE(PS),
    .START_DLY(SD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .en(en),
    .uvlo_ok(uvlo_ok),
    .fault(fault),
    .ilim(ilim),
    .ss_code(ss_code),
    .tstate(tstate),
    .step_pulse(step_pulse),
    .ss_ok(ss_ok),
    .ss_done(ss_done),
    .CELV(CELV),
    .CELG(CELG),
    .SUB(SUB)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    m_act = 0; m_n = 0; m_code = 0; m_pulse = 0; m_ok = 0;
  endtask

  task automatic model_edge();
    bit ab;
    ab = !en || !uvlo_ok || fault;
    m_ok = !ab;
    m_pulse = 0;
    if (ab) begin
      m_act = 0; m_code = 0;
    end else if (!m_act) begin
      m_act = 1; m_n = 0; m_code = 0;
    end else begin
      m_n++;
      if (m_n >= SD + PS && (m_n - SD) % PS == 0 && !ilim && m_code < FULL) begin
        m_code++;
        m_pulse = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("ss_code", 32'(ss_code), 32'(m_code));
    chk("tstate", 32'(tstate), 32'(m_act && m_n >= SD && m_code < FULL));
    chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
    chk("ss_ok", 32'(ss_ok), 32'(m_ok));
    chk("ss_done", 32'(ss_done), 32'(m_act && m_code == FULL));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    en = 0; uvlo_ok = 0; fault = 0; ilim = 0;
    RST = 1;
    model_reset();
    #1;
    chk("rst_code", 32'(ss_code), 0);
    chk("rst_tstate", 32'(tstate), 0);
    chk("rst_pulse", 32'(step_pulse), 0);
    chk("rst_ok", 32'(ss_ok), 0);
    chk("rst_done", 32'(ss_done), 0);
    @(negedge CLK);
    RST = 0;
  endtask

  initial begin
    int first_t, npulse, done_c, hold4, hold_p;

    // Nominal ramp
    do_reset();
    en = 1; uvlo_ok = 1;
    cyc = -1; first_t = -1; npulse = 0; done_c = -1;
    repeat (70) begin
      step();
      if (tstate && first_t < 0) first_t = cyc;
      if (step_pulse) npulse++;
      if (ss_done && done_c < 0) done_c = cyc;
    end
    chk("nom_tstate_rise", 32'(first_t), 3);
    chk("nom_pulses", 32'(npulse), 15);
    chk("nom_done_cycle", 32'(done_c), 63);

    // DONE hold with ilim toggling
    hold_p = 0;
    repeat (100) begin
      ilim = 1'($urandom);
      step();
      if (step_pulse) hold_p++;
    end
    ilim = 0;
    chk("hold_pulses", 32'(hold_p), 0);
    chk("hold_code", 32'(ss_code), 15);
    chk("hold_done", 32'(ss_done), 1);

    // Current-limit pause on steps 5 and 6
    do_reset();
    en = 1; uvlo_ok = 1;
    cyc = -1; done_c = -1; hold4 = 0;
    repeat (80) begin
      ilim = (cyc + 1 == 23 || cyc + 1 == 27);
      step();
      if (ss_code == 4) hold4++;
      if (ss_done && done_c < 0) done_c = cyc;
    end
    ilim = 0;
    chk("pause_hold4", 32'(hold4), 12);
    chk("pause_done_cycle", 32'(done_c), 71);

    // Abort mid-ramp at code 9, then restart
    do_reset();
    en = 1; uvlo_ok = 1;
    cyc = -1;
    for (int i = 0; i < 80 && ss_code != 9; i++) step();
    chk("abort_reach9", 32'(ss_code), 9);
    uvlo_ok = 0;
    step();
    chk("abort_code", 32'(ss_code), 0);
    chk("abort_tstate", 32'(tstate), 0);
    chk("abort_ok", 32'(ss_ok), 0);
    uvlo_ok = 1;
    cyc = -1; first_t = -1;
    for (int i = 0; i < 20 && first_t < 0; i++) begin
      step();
      if (step_pulse) first_t = cyc;
    end
    chk("restart_first_step", 32'(first_t), 7);

    // Fault on the edge of the final increment
    do_reset();
    en = 1; uvlo_ok = 1;
    cyc = -1; done_c = -1;
    while (cyc < 62) begin
      step();
      if (ss_done) done_c = cyc;
    end
    fault = 1;
    step();
    fault = 0;
    chk("sim_code", 32'(ss_code), 0);
    chk("sim_done", 32'(ss_done), 0);
    chk("sim_done_seen", 32'(done_c), 32'(-1));

    // Async reset between edges during RAMP
    do_reset();
    en = 1; uvlo_ok = 1;
    cyc = -1;
    repeat (20) step();
    #2;
    RST = 1;
    model_reset();
    #1;
    chk("arst_code", 32'(ss_code), 0);
    chk("arst_tstate", 32'(tstate), 0);
    chk("arst_ok", 32'(ss_ok), 0);
    @(negedge CLK);
    RST = 0;
    cyc = -1; first_t = -1;
    step();
    chk("arst_wait_ok", 32'(ss_ok), 1);
    chk("arst_wait_code", 32'(ss_code), 0);
    repeat (5) begin
      step();
      if (tstate && first_t < 0) first_t = cyc;
    end
    chk("arst_tstate_rise", 32'(first_t), 3);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 199) != 0);
      uvlo_ok = ($urandom_range(0, 299) != 0);
      fault   = ($urandom_range(0, 299) == 0);
      ilim    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stepdown_softstart_seq.md
# stepdown_softstart_seq

Soft-start sequencer for the step-down converter. On enable it waits a programmable start delay, then ramps a reference code from zero to full scale in fixed-rate steps. It pauses the ramp while current limit is active and aborts to zero on disable, UVLO or fault. Its `tstate`, `step_pulse` and `ss_ok` outputs drive the soft-start gating stage, the 3-input AND (nand3 + inv) on `Tstate`, `i0` and `i1`, that sits directly downstream inside the soft-start block.

## Interface

Clocking and reset are fixed: one clock, `CLK`. Reset `RST` is asynchronous and active-high.

Parameters:
- `CODE_W`, default 6: width of the ramp code; full scale is 2^CODE_W−1.
- `PRESCALE`, default 16: clocks per ramp step. Must be ≥2.
- `START_DLY`, default 8: clocks spent in WAIT before the ramp starts. Must be ≥1.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  asynchronous active-high reset.
- `en`  in  1  converter enable request (synchronous to CLK).
- `uvlo_ok`  in  1  supply above UVLO threshold.
- `fault`  in  1  fault flag (OCP/OTP); any high cycle aborts the sequence.
- `ilim`  in  1  cycle current limit active; pauses stepping.
- `ss_code`  out  CODE_W  reference ramp code to the soft-start DAC.
- `tstate`  out  1  ramp-active strobe; feeds `Tstate` of the gating stage.
- `step_pulse`  out  1  one-cycle pulse per code increment; feeds `i0`.
- `ss_ok`  out  1  high while `en && uvlo_ok && !fault` is registered; feeds `i1`.
- `ss_done`  out  1  ramp complete; code at full scale.
- `CELV`, `CELG`, `SUB`  in  1  supply, ground and substrate pins. They carry no logic function and are passed to any instantiated cells.

## Operation

- All outputs are registered. Reset values: `ss_code=0`, `tstate=0`, `step_pulse=0`, `ss_ok=0`, `ss_done=0`, state IDLE, all counters 0.
- Abort condition: `abort = !en || !uvlo_ok || fault`, sampled each edge.
  - Abort has priority over every transition.
  - On abort the next state is IDLE and `ss_code`, the prescaler and the delay counter clear to 0 on that edge.
  - `ss_ok` is the registered value of `!abort`.
- **IDLE:** outputs are at reset values apart from `ss_ok`. If `!abort`, go to WAIT and clear the delay counter.
- **WAIT:** the delay counter increments each cycle. When it equals START_DLY−1, go to RAMP and clear the prescaler. `tstate=0`.
- **RAMP:** `tstate=1`. The prescaler counts 0..PRESCALE−1 and wraps.
  - When the prescaler is at PRESCALE−1 and `ilim=0`: on the next edge `ss_code` increments by 1 and `step_pulse` is 1 for exactly that cycle.
  - When the prescaler is at PRESCALE−1 and `ilim=1`: the prescaler still wraps, but there is no increment and no pulse (pause).
  - When an increment makes `ss_code` equal to 2^CODE_W−1, the same edge moves to DONE.
- **DONE:** `ss_code` holds full scale, `ss_done=1`, `tstate=0`, `step_pulse=0`. It stays here until abort.
- `ss_code` never wraps past full scale and never decrements except through the abort clear.
- Re-enable after abort always restarts from IDLE → WAIT with the code at 0.

## Timing

- `en` rises with `uvlo_ok=1` and `fault=0` at edge T0 sampling:
  - WAIT and `ss_ok=1` at T0.
  - RAMP and `tstate=1` at T0+START_DLY.
- First `step_pulse` and `ss_code=1` occur at T0+START_DLY+PRESCALE.
- Successive steps are spaced exactly PRESCALE cycles apart. Each paused slot (ilim=1 at terminal count) adds PRESCALE cycles.
- With no pauses, `ss_done` rises at T0+START_DLY+(2^CODE_W−1)·PRESCALE. `tstate` falls on that same edge.
- Abort latency: one edge. Outputs clear on the edge that samples abort.
- `ilim` is evaluated only at prescaler terminal count. Changes at other counts have no effect.
- Asynchronous RST forces reset values immediately, regardless of CLK. Release takes effect on the next edge.

## Test plan

All scenarios use CODE_W=4, PRESCALE=4, START_DLY=3.

- **Nominal ramp:** `en=1`, `uvlo_ok=1` from cycle 0 → `tstate` rises at cycle 3. `step_pulse` occurs at 7, 11, …, 63. `ss_code=15` and `ss_done=1` at cycle 63. Exactly 15 pulses.
- **Current-limit pause:** hold `ilim=1` during the prescaler terminal counts of steps 5 and 6 → `ss_code` holds at 4 for 12 cycles. `ss_done` slips by 8 cycles to 71.
- **Abort mid-ramp:** drop `uvlo_ok` at `ss_code=9` → next edge gives `ss_code=0`, `tstate=0`, `ss_ok=0`, state IDLE. Restoring it produces a full restart, with the first step 7 cycles later.
- **Simultaneous events:** `fault=1` on the same edge as the final increment → `ss_code=0` and `ss_done` never asserts.
- **Async reset:** assert RST between clock edges during RAMP → all outputs go to 0 without a clock edge. After release with `en=1`, WAIT begins on the next edge.
- **DONE hold:** keep `en=1` for 100 cycles after done → `ss_code=15`, `ss_done=1`, no `step_pulse`. `ilim` toggling has no effect.
